// File: rtl/cpu_core.sv
// ============================================================================
// cpu_core : 8-bit load/store CPU, 16 x 8-bit registers, 16-bit PC
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] iMemAddress,
  input  logic [15:0] iMemOut,
  output logic        iMemReadEnable,
  output logic [15:0] dMemIOAddress,
  output logic [7:0]  dMemIOIn,
  input  logic [15:0] dMemIOOut,
  output logic        dMemIOWriteEn,
  output logic        dMemIOReadEn,
  output logic        halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [15:0] pc;
  logic [7:0]  rf [16];
  logic        z, c, n;
  logic [3:0]  load_rd;

  logic [3:0]  op, rd_idx, rs_idx, func;
  logic [7:0]  imm8, rd_val, rs_val;
  logic [15:0] pair_addr;

  logic        wr_en, flag_en, take, is_ld, is_st, is_hlt;
  logic [7:0]  wr_data, res;
  logic [8:0]  sum9;
  logic        z_new, c_new, n_new;
  logic [15:0] pc_target;
  logic        unused_bits;

  assign op        = iMemOut[15:12];
  assign rd_idx    = iMemOut[11:8];
  assign rs_idx    = iMemOut[7:4];
  assign func      = iMemOut[3:0];
  assign imm8      = iMemOut[7:0];
  assign rd_val    = rf[rd_idx];
  assign rs_val    = rf[rs_idx];
  assign pair_addr = {rf[{rs_idx[3:1], 1'b1}], rf[{rs_idx[3:1], 1'b0}]};
  assign unused_bits = ^dMemIOOut[15:8];

  always_comb begin
    case (rd_idx)
      4'h0:    take = 1'b1;
      4'h1:    take = z;
      4'h2:    take = ~z;
      4'h3:    take = c;
      4'h4:    take = ~c;
      4'h5:    take = n;
      4'h6:    take = ~n;
      default: take = 1'b0;
    endcase
  end

  // Instruction decode and execute; subtraction borrow is bit 8 of a 9-bit difference.
  always_comb begin
    wr_en     = 1'b0;
    wr_data   = rd_val;
    flag_en   = 1'b0;
    res       = 8'h00;
    sum9      = 9'h000;
    z_new     = z;
    c_new     = c;
    n_new     = n;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    is_hlt    = 1'b0;
    pc_target = pc + 16'd1;
    case (op)
      4'h1: begin wr_en = 1'b1; wr_data = imm8; end
      4'h2: begin
        case (func)
          4'h0: begin wr_en = 1'b1; wr_data = rs_val; end
          4'h1: begin sum9 = {1'b0, rd_val} + {1'b0, rs_val}; res = sum9[7:0]; c_new = sum9[8]; wr_en = 1'b1; flag_en = 1'b1; end
          4'h2: begin sum9 = {1'b0, rd_val} + {1'b0, rs_val} + {8'h00, c}; res = sum9[7:0]; c_new = sum9[8]; wr_en = 1'b1; flag_en = 1'b1; end
          4'h3: begin sum9 = {1'b0, rd_val} - {1'b0, rs_val}; res = sum9[7:0]; c_new = sum9[8]; wr_en = 1'b1; flag_en = 1'b1; end
          4'h4: begin res = rd_val & rs_val; c_new = 1'b0; wr_en = 1'b1; flag_en = 1'b1; end
          4'h5: begin res = rd_val | rs_val; c_new = 1'b0; wr_en = 1'b1; flag_en = 1'b1; end
          4'h6: begin res = rd_val ^ rs_val; c_new = 1'b0; wr_en = 1'b1; flag_en = 1'b1; end
          4'h7: begin sum9 = {1'b0, rd_val} - {1'b0, rs_val}; res = sum9[7:0]; c_new = sum9[8]; flag_en = 1'b1; end
          4'h8: begin res = ~rd_val; c_new = 1'b0; wr_en = 1'b1; flag_en = 1'b1; end
          4'h9: begin res = {rd_val[6:0], 1'b0}; c_new = rd_val[7]; wr_en = 1'b1; flag_en = 1'b1; end
          4'hA: begin res = {1'b0, rd_val[7:1]}; c_new = rd_val[0]; wr_en = 1'b1; flag_en = 1'b1; end
          default: ;
        endcase
        if (func != 4'h0) wr_data = res;
      end
      4'h3: begin sum9 = {1'b0, rd_val} + {1'b0, imm8}; res = sum9[7:0]; c_new = sum9[8]; wr_en = 1'b1; wr_data = res; flag_en = 1'b1; end
      4'h4: begin sum9 = {1'b0, rd_val} - {1'b0, imm8}; res = sum9[7:0]; c_new = sum9[8]; wr_en = 1'b1; wr_data = res; flag_en = 1'b1; end
      4'h5: begin sum9 = {1'b0, rd_val} - {1'b0, imm8}; res = sum9[7:0]; c_new = sum9[8]; flag_en = 1'b1; end
      4'h6: is_ld = 1'b1;
      4'h7: is_st = 1'b1;
      4'h8: if (take) pc_target = pc + 16'd1 + {{8{imm8[7]}}, imm8};
      4'h9: if (take) pc_target = pair_addr;
      4'hF: is_hlt = 1'b1;
      default: ;
    endcase
    if (flag_en) begin
      z_new = (res == 8'h00);
      n_new = res[7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_hlt ? S_HALT : (is_ld ? S_LOAD : S_FETCH);
      S_LOAD:  state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // Bus strobes are gated by rst_n so nothing leaks while reset is held.
  always_comb begin
    iMemAddress    = pc;
    iMemReadEnable = rst_n && (state == S_FETCH);
    dMemIOAddress  = 16'h0000;
    dMemIOIn       = 8'h00;
    dMemIOWriteEn  = 1'b0;
    dMemIOReadEn   = 1'b0;
    halted         = (state == S_HALT);
    if (rst_n && state == S_EXEC && (is_ld || is_st)) begin
      dMemIOAddress = pair_addr;
      dMemIOIn      = is_st ? rd_val : 8'h00;
      dMemIOWriteEn = is_st;
      dMemIOReadEn  = is_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      z       <= 1'b0;
      c       <= 1'b0;
      n       <= 1'b0;
      load_rd <= 4'h0;
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else begin
      if (state == S_EXEC) begin
        if (!is_hlt) pc <= pc_target;
        if (wr_en)   rf[rd_idx] <= wr_data;
        if (is_ld)   load_rd <= rd_idx;
        z <= z_new;
        c <= c_new;
        n <= n_new;
      end
      if (state == S_LOAD) rf[load_rd] <= dMemIOOut[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_core.sv
// ============================================================================
// tb_cpu_core : directed table-driven bench for cpu_core
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] iMemAddress;
  logic [15:0] iMemOut = 16'h0000;
  logic        iMemReadEnable;
  logic [15:0] dMemIOAddress;
  logic [7:0]  dMemIOIn;
  logic [15:0] dMemIOOut = 16'h0000;
  logic        dMemIOWriteEn;
  logic        dMemIOReadEn;
  logic        halted;

  cpu_core #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .iMemAddress(iMemAddress), .iMemOut(iMemOut), .iMemReadEnable(iMemReadEnable),
    .dMemIOAddress(dMemIOAddress), .dMemIOIn(dMemIOIn), .dMemIOOut(dMemIOOut),
    .dMemIOWriteEn(dMemIOWriteEn), .dMemIOReadEn(dMemIOReadEn), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [7:0]  dmem [65536];
  logic [15:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          conflicts = 0;
  int          fetch_halted = 0;
  logic        saw_ffff = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Memory models: 1-cycle synchronous reads, store logging.
  always @(posedge clk) begin
    if (iMemReadEnable) iMemOut <= imem[iMemAddress[7:0]];
    if (iMemReadEnable && iMemAddress == 16'hFFFF) saw_ffff = 1'b1;
    if (halted && iMemReadEnable) fetch_halted++;
    if (dMemIOWriteEn && dMemIOReadEn) conflicts++;
    if (dMemIOReadEn) dMemIOOut <= {8'h00, dmem[dMemIOAddress]};
    if (dMemIOWriteEn) begin
      dmem[dMemIOAddress] = dMemIOIn;
      wa_q.push_back(dMemIOAddress);
      wd_q.push_back(dMemIOIn);
    end
  end

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [7:0]  res;
    logic        z;
    logic        c;
    logic        n;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    saw_ffff = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input string name, input int maxc, output int cycles);
    cycles = 0;
    while (!halted && cycles < maxc) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({name, "_halt"}, {31'h0, halted}, 32'h1);
  endtask

  task automatic build_vec(input vec_t v);
    clear_imem();
    imem[0]  = 16'h1410;
    imem[1]  = 16'h1500;
    imem[2]  = 16'h1300;
    imem[3]  = {8'h53, 7'h00, v.cin};
    imem[4]  = {8'h11, v.a};
    imem[5]  = {8'h12, v.b};
    imem[6]  = v.instr;
    imem[7]  = 16'h1700;
    imem[8]  = 16'h8201;
    imem[9]  = 16'h1701;
    imem[10] = 16'h1800;
    imem[11] = 16'h8401;
    imem[12] = 16'h1801;
    imem[13] = 16'h1900;
    imem[14] = 16'h8601;
    imem[15] = 16'h1901;
    imem[16] = 16'h7140;
    imem[17] = 16'h7740;
    imem[18] = 16'h7840;
    imem[19] = 16'h7940;
    imem[20] = 16'hF000;
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{16'h2121, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h3101, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{16'h4101, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{16'h2122, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'h2122, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h2123, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{16'h2123, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{16'h2124, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h2125, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'h2126, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{16'h2127, 8'h10, 8'h20, 1'b0, 8'h10, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{16'h2128, 8'h0F, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{16'h2129, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{16'h212A, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{16'h2120, 8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{16'h5108, 8'h08, 8'h00, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{16'h212B, 8'h12, 8'h34, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{16'h2111, 8'h80, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{16'hA1FF, 8'h33, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};

    clear_imem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ifetch_en", {31'h0, iMemReadEnable}, 32'h0);
    check("rst_wr_en", {31'h0, dMemIOWriteEn}, 32'h0);
    check("rst_rd_en", {31'h0, dMemIOReadEn}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_pc", {16'h0, iMemAddress}, 32'h0000);
    check("rst_fetch", {31'h0, iMemReadEnable}, 32'h1);

    // ALU / flag vectors: result and flags read back through stores.
    for (int i = 0; i < 19; i++) begin
      build_vec(vecs[i]);
      do_reset();
      run_until_halt($sformatf("vec%0d", i), 300, cyc);
      check($sformatf("vec%0d_nstores", i), wa_q.size(), 4);
      if (wa_q.size() == 4) begin
        check($sformatf("vec%0d_res", i), {24'h0, wd_q[0]}, {24'h0, vecs[i].res});
        check($sformatf("vec%0d_z", i), {24'h0, wd_q[1]}, {31'h0, vecs[i].z});
        check($sformatf("vec%0d_c", i), {24'h0, wd_q[2]}, {31'h0, vecs[i].c});
        check($sformatf("vec%0d_n", i), {24'h0, wd_q[3]}, {31'h0, vecs[i].n});
        check($sformatf("vec%0d_addr", i), {16'h0, wa_q[0]}, 32'h0010);
      end
    end

    // Store / load / IO stores and cycle count.
    clear_imem();
    imem[0] = 16'h1410; imem[1] = 16'h1500; imem[2] = 16'h10A5;
    imem[3] = 16'h7040; imem[4] = 16'h6340; imem[5] = 16'h7340;
    imem[6] = 16'h1600; imem[7] = 16'h1710; imem[8] = 16'h7060;
    imem[9] = 16'h1720; imem[10] = 16'h7360; imem[11] = 16'hF000;
    dmem[16'h0010] = 8'h00;
    do_reset();
    fetch_halted = 0;
    run_until_halt("ldst", 200, cyc);
    check("ldst_cycles", cyc, 25);
    check("ldst_nstores", wa_q.size(), 4);
    if (wa_q.size() == 4) begin
      check("st0_addr", {16'h0, wa_q[0]}, 32'h0010);
      check("st0_data", {24'h0, wd_q[0]}, 32'hA5);
      check("ld_data", {24'h0, wd_q[1]}, 32'hA5);
      check("io_addr", {16'h0, wa_q[2]}, 32'h1000);
      check("io_data", {24'h0, wd_q[2]}, 32'hA5);
      check("far_addr", {16'h0, wa_q[3]}, 32'h2000);
      check("far_data", {24'h0, wd_q[3]}, 32'hA5);
    end
    repeat (5) @(posedge clk);
    #1;
    check("halt_no_fetch", fetch_halted, 0);
    check("halt_sticky", {31'h0, halted}, 32'h1);
    check("rw_conflict", conflicts, 0);

    // Branch loop, not-taken branch, indirect jump.
    clear_imem();
    imem[0] = 16'h1410; imem[1] = 16'h1500; imem[2] = 16'h1103;
    imem[3] = 16'h7140; imem[4] = 16'h4101; imem[5] = 16'h82FD;
    imem[6] = 16'h8205; imem[7] = 16'h7140; imem[8] = 16'h160C;
    imem[9] = 16'h1700; imem[10] = 16'h9060; imem[11] = 16'hF000;
    imem[12] = 16'h125A; imem[13] = 16'h7240; imem[14] = 16'hF000;
    do_reset();
    run_until_halt("branch", 300, cyc);
    check("branch_nstores", wa_q.size(), 5);
    if (wa_q.size() == 5) begin
      check("loop_w0", {24'h0, wd_q[0]}, 32'h03);
      check("loop_w1", {24'h0, wd_q[1]}, 32'h02);
      check("loop_w2", {24'h0, wd_q[2]}, 32'h01);
      check("br_not_taken", {24'h0, wd_q[3]}, 32'h00);
      check("jmp_target", {24'h0, wd_q[4]}, 32'h5A);
    end

    // PC wrap through 0xFFFF.
    clear_imem();
    imem[0] = 16'h16FF; imem[1] = 16'h17FF; imem[2] = 16'h9060;
    imem[8'hFF] = 16'h8010;
    imem[8'h10] = 16'h1440; imem[8'h11] = 16'h1500; imem[8'h12] = 16'h7640;
    imem[8'h13] = 16'hF000;
    do_reset();
    run_until_halt("wrap", 200, cyc);
    check("wrap_saw_ffff", {31'h0, saw_ffff}, 32'h1);
    check("wrap_nstores", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      check("wrap_addr", {16'h0, wa_q[0]}, 32'h0040);
      check("wrap_data", {24'h0, wd_q[0]}, 32'hFF);
    end

    // Reset asserted while an LD is in EXEC.
    clear_imem();
    imem[0] = 16'h1410; imem[1] = 16'h1500; imem[2] = 16'h6340; imem[3] = 16'hF000;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("ld_exec_rden", {31'h0, dMemIOReadEn}, 32'h1);
    check("ld_exec_addr", {16'h0, dMemIOAddress}, 32'h0010);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rden", {31'h0, dMemIOReadEn}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_mid_fetch", {31'h0, iMemReadEnable}, 32'h0);
    check("rst_mid_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_pc", {16'h0, iMemAddress}, 32'h0000);
    check("rst_mid_state", {31'h0, iMemReadEnable}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
